// File: rtl/grey_incr_arb.sv
// grey_incr_arb: round-robin arbiter that turns per-requester increment
// requests into spaced, one-hot-granted increment strobes for a grey counter.
//
// Ports:
//   clk        rising-edge clock
//   w_rst      synchronous active-high reset
//   enable     level-sensitive grant-issue enable
//   req        per-requester increment request (one cycle = one increment)
//   div_val    idle cycles between consecutive incr_sync pulses
//   ovf_clr    clears all pend_ovf bits
//   incr_sync  one-cycle increment strobe (registered)
//   gnt        one-hot grant, coincident with incr_sync (registered)
//   pend_ovf   sticky pending-counter overflow flags
//   busy       FSM not idle or any request still pending
//
// Build option: define GREY_ARB_PRIO0_EN to give requester 0 absolute
// priority; otherwise arbitration is pure round-robin.

module grey_incr_arb #(
    parameter int NREQ  = 4,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             w_rst,
    input  logic             enable,
    input  logic [NREQ-1:0]  req,
    input  logic [DIV_W-1:0] div_val,
    input  logic             ovf_clr,
    output logic             incr_sync,
    output logic [NREQ-1:0]  gnt,
    output logic [NREQ-1:0]  pend_ovf,
    output logic             busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     spacer_q, spacer_d;
    logic [PW-1:0]        ptr_q, ptr_d;
    logic [NREQ-1:0][1:0] pend_q, pend_d;
    logic [NREQ-1:0]      ovf_q, ovf_d, ovf_evt;
    logic [NREQ-1:0]      gnt_q, gnt_d;
    logic                 incr_q, incr_d;
    logic [NREQ-1:0]      has_pend;
    logic [NREQ-1:0]      win;
    logic [PW-1:0]        win_idx;
    logic                 win_prio;
    logic                 any_pend;
    logic                 go_grant;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            has_pend[i] = |pend_q[i];
        end
    end

    assign any_pend = |has_pend;

    // Round-robin search starting at ptr_q; first pending index wins.
    always_comb begin
        int  idx;
        logic found;
        win      = '0;
        win_idx  = ptr_q;
        win_prio = 1'b0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && has_pend[idx]) begin
                found        = 1'b1;
                win[idx]     = 1'b1;
                win_idx      = PW'(idx);
            end
        end
`ifdef GREY_ARB_PRIO0_EN
        // Requester 0 overrides the rotation and leaves the pointer alone.
        if (has_pend[0]) begin
            win      = '0;
            win[0]   = 1'b1;
            win_idx  = '0;
            win_prio = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        spacer_d = spacer_q;
        go_grant = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable && any_pend) begin
                    go_grant = 1'b1;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (div_val != '0) begin
                    state_d  = S_GAP;
                    spacer_d = div_val;
                end else if (enable && any_pend) begin
                    go_grant = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                spacer_d = spacer_q - DIV_W'(1);
                if (spacer_q == DIV_W'(1)) begin
                    if (enable && any_pend) begin
                        go_grant = 1'b1;
                        state_d  = S_GRANT;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        gnt_d  = go_grant ? win : '0;
        incr_d = go_grant;
        ptr_d  = ptr_q;
        if (go_grant && !win_prio) begin
            ptr_d = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

    // Pending counters: a grant and a request in the same cycle cancel out.
    always_comb begin
        pend_d  = pend_q;
        ovf_evt = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req[i] && !gnt_d[i]) begin
                if (pend_q[i] == 2'd3) begin
                    ovf_evt[i] = 1'b1;
                end else begin
                    pend_d[i] = pend_q[i] + 2'd1;
                end
            end else if (!req[i] && gnt_d[i]) begin
                pend_d[i] = pend_q[i] - 2'd1;
            end
        end
        ovf_d = (ovf_clr ? '0 : ovf_q) | ovf_evt;
    end

    always_ff @(posedge clk) begin
        if (w_rst) begin
            state_q  <= S_IDLE;
            spacer_q <= '0;
            ptr_q    <= '0;
            pend_q   <= '0;
            ovf_q    <= '0;
            gnt_q    <= '0;
            incr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            spacer_q <= spacer_d;
            ptr_q    <= ptr_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
            gnt_q    <= gnt_d;
            incr_q   <= incr_d;
        end
    end

    assign incr_sync = incr_q;
    assign gnt       = gnt_q;
    assign pend_ovf  = ovf_q;
    assign busy      = (state_q != S_IDLE) || any_pend;

endmodule
